// File: rtl/spi_pkg.sv
// Shared SPI definitions for the slave and the companion master.
// Contents: FSM state encodings, default word width, Mode 0 clock constants.
package spi_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  // Mode 0: sclk idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

endpackage

// File: rtl/spi_slave_if.sv
// Bus bundle between the SPI slave and its surroundings.
// Signals: sclk/ss_n/mosi (from SPI master), miso/miso_oe (to pad),
//          tx_data/tx_load/tx_ready (tx buffer write side),
//          rx_data/rx_valid (received words), busy, underrun (status).
// Modports: slave (the spi_slave block), master (everything driving it).
interface spi_slave_if #(
  parameter int unsigned DATA_W = spi_pkg::DATA_W_DEF
);
  logic              sclk;
  logic              ss_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              underrun;

  modport slave (
    input  sclk, ss_n, mosi, tx_data, tx_load,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun
  );

  modport master (
    output sclk, ss_n, mosi, tx_data, tx_load,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection in the clk domain.
// Ports: clk, rst_n (async active-low), i_async (asynchronous input),
//        o_sync (synchronised level), o_rise / o_fall (one-cycle edge pulses).
// RESET_VAL sets the idle level the chain (and edge history) resets to,
// so no spurious edge appears when reset is released.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise =  o_sync & ~r_prev;
  assign o_fall = ~o_sync &  r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI Mode 0 slave, oversampled in the clk domain (nothing is clocked by sclk).
// Ports: clk, rst_n (async active-low) and the spi_slave_if.slave bundle:
//   sclk/ss_n/mosi in, miso/miso_oe out, tx_data/tx_load in, tx_ready out,
//   rx_data/rx_valid out, busy out, underrun out (sticky).
// Build option: define SPI_SLAVE_LSB_FIRST_EN for LSB-first shifting on both
// directions; default is MSB first.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_slave_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  function automatic logic [DATA_W-1:0] f_rx_shift(input logic [DATA_W-1:0] cur,
                                                   input logic b);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return {b, cur[DATA_W-1:1]};
`else
    return {cur[DATA_W-2:0], b};
`endif
  endfunction

  function automatic logic f_first_bit(input logic [DATA_W-1:0] v);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return v[0];
`else
    return v[DATA_W-1];
`endif
  endfunction

  function automatic logic [DATA_W-1:0] f_tx_advance(input logic [DATA_W-1:0] v);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return v >> 1;
`else
    return v << 1;
`endif
  endfunction

  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_ss_sync,   w_ss_rise,   w_ss_fall;
  logic w_mosi_sync, w_mosi_rise, w_mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_async(bus.sclk),
    .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .i_async(bus.ss_n),
    .o_sync(w_ss_sync), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .i_async(bus.mosi),
    .o_sync(w_mosi_sync), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  // Deselect is acted on by level, so the ss_n rise pulse is not needed.
  logic w_unused_sync;
  assign w_unused_sync = &{1'b0, w_sclk_sync, w_ss_rise, w_mosi_rise, w_mosi_fall};

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_tx_buf;
  logic              r_tx_full;
  logic [DATA_W-1:0] r_tx_shift;
  logic [DATA_W-1:0] r_rx_shift;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_word_done;
  logic              r_miso;
  logic              r_miso_oe;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_underrun;

  logic              w_consume;
  logic [DATA_W-1:0] w_load_val;
  logic [DATA_W-1:0] w_rx_next;
  logic [DATA_W-1:0] w_tx_next;

  // Buffer is consumed at LOAD and at the first sclk fall after a word ends,
  // unless deselect wins the same cycle.
  assign w_consume  = ~w_ss_sync &
                      ((r_state == ST_LOAD) ||
                       ((r_state == ST_SHIFT) && w_sclk_fall && r_word_done));
  assign w_load_val = r_tx_full ? r_tx_buf : '0;
  assign w_rx_next  = f_rx_shift(r_rx_shift, w_mosi_sync);
  assign w_tx_next  = f_tx_advance(r_tx_shift);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_tx_buf    <= '0;
      r_tx_full   <= 1'b0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_bit_cnt   <= '0;
      r_word_done <= 1'b0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;

      // A consume frees the slot before a same-cycle write is considered.
      if (bus.tx_load && (!r_tx_full || w_consume)) begin
        r_tx_buf  <= bus.tx_data;
        r_tx_full <= 1'b1;
        if (w_ss_sync) r_underrun <= 1'b0;
      end else if (w_consume) begin
        r_tx_full <= 1'b0;
      end

      if ((r_state != ST_IDLE) && w_ss_sync) begin
        r_state     <= ST_IDLE;
        r_miso_oe   <= 1'b0;
        r_miso      <= 1'b0;
        r_bit_cnt   <= '0;
        r_word_done <= 1'b0;
        r_rx_shift  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
            if (w_ss_fall) r_state <= ST_LOAD;
          end
          ST_LOAD: begin
            r_tx_shift  <= w_load_val;
            r_miso      <= f_first_bit(w_load_val);
            r_miso_oe   <= 1'b1;
            r_bit_cnt   <= '0;
            r_word_done <= 1'b0;
            r_rx_shift  <= '0;
            if (!r_tx_full) r_underrun <= 1'b1;
            r_state <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (w_sclk_rise) begin
              r_rx_shift <= w_rx_next;
              if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                r_rx_data   <= w_rx_next;
                r_rx_valid  <= 1'b1;
                r_bit_cnt   <= '0;
                r_word_done <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else if (w_sclk_fall) begin
              if (r_word_done) begin
                r_tx_shift  <= w_load_val;
                r_miso      <= f_first_bit(w_load_val);
                r_word_done <= 1'b0;
                if (!r_tx_full) r_underrun <= 1'b1;
              end else begin
                r_tx_shift <= w_tx_next;
                r_miso     <= f_first_bit(w_tx_next);
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.miso     = r_miso;
  assign bus.miso_oe  = r_miso_oe;
  assign bus.tx_ready = ~r_tx_full;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.busy     = ~w_ss_sync;
  assign bus.underrun = r_underrun;

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI Mode 0 slave (CPOL=0, CPHA=0), MSB first by default: the responder end of the team's SPI master link.
- Oversamples `sclk`, `ss_n` and `mosi` in the system clock domain; no logic is clocked by `sclk`.
- Deserialises MOSI bytes into a one-cycle `rx_valid` pulse.
- Serialises a buffered transmit byte on MISO, with back-to-back bytes while `ss_n` stays low.

Parameters:
- DATA_W, 8: bits per SPI word.
- SYNC_STAGES, 2: synchroniser flops on `sclk`, `ss_n` and `mosi`; minimum 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- sclk  in  1  SPI serial clock from master, asynchronous to `clk`.
- ss_n  in  1  slave select, active-low, asynchronous.
- mosi  in  1  master out slave in, asynchronous.
- miso  out  1  serial data to master; valid only while `miso_oe`=1.
- miso_oe  out  1  output enable for the pad tri-state; high only while selected.
- tx_data  in  DATA_W  next byte to return to master.
- tx_load  in  1  write strobe; captures `tx_data` into the tx buffer when `tx_ready`=1.
- tx_ready  out  1  tx buffer empty.
- rx_data  out  DATA_W  last complete received word; held until the next word completes.
- rx_valid  out  1  one-`clk` pulse when `rx_data` updates.
- busy  out  1  selected (synchronised `ss_n`=0).
- underrun  out  1  sticky; set when a word started with an empty tx buffer; cleared by a `tx_load` accepted while `ss_n` is deasserted.

Behaviour:
- Reset values: `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `busy`=0, `underrun`=0.
  - Internally: shift registers 0, bit counter 0, synchronisers reset to idle levels (`sclk`=0, `ss_n`=1, `mosi`=0).
- Synchronisation: each input passes through SYNC_STAGES flops. Edge detect compares the last synced value with one further registered copy.
- Timing requirement on the master: each `sclk` high and low phase ≥ SYNC_STAGES+2 `clk` periods. `ss_n` setup to the first `sclk` rise ≥ SYNC_STAGES+2 `clk` periods.
- States:
  - IDLE: `ss_n` high, `miso_oe`=0. On synced `ss_n` fall go to LOAD.
  - LOAD: one cycle. Copy the tx buffer into the tx shift register (or 0 if the buffer is empty, and set `underrun`). Mark the buffer empty (`tx_ready`=1). Present the MSB on `miso`, set `miso_oe`=1, bit counter=0. Go to SHIFT.
  - SHIFT, on `sclk` rise:
    - Shift synced `mosi` into the rx shift register LSB; bit counter +1.
    - When the counter reaches DATA_W: in the same cycle `rx_data` ← completed word, `rx_valid`=1, counter ← 0, set the word-done flag.
  - SHIFT, on `sclk` fall:
    - If word-done is set: reload the tx shift register from the buffer (0 and `underrun` if empty), present its MSB, clear word-done.
    - Otherwise shift the tx register left and present the next bit.
  - SHIFT, on synced `ss_n` rise (any state except IDLE): go to IDLE immediately.
    - Drop `miso_oe`; clear the bit counter and word-done.
    - Discard the partial rx word; no `rx_valid`.
    - The tx buffer keeps its content if it was not yet consumed.
- tx buffer: one entry. `tx_load` with `tx_ready`=0 is ignored (no overwrite). `tx_load` in the same cycle as a buffer consume: consume first, then the new data is accepted (`tx_ready` stays 0).
- `rx_valid` is never asserted for two consecutive cycles; the next word is ≥ 2·DATA_W·(SYNC_STAGES+2) cycles later.
- Reset mid-transfer: all state returns to reset values immediately. The master must deassert `ss_n` before restarting.

Optional Feature:
- SPI_SLAVE_LSB_FIRST_EN.
  - Defined: rx shifts in at the MSB toward the LSB; tx presents bit 0 first and shifts right.
  - Undefined: MSB first as above.
  - Handshake and timing are identical in both builds.

Decomposition:
- spi_pkg:
  - state encoding localparams (IDLE, LOAD, SHIFT)
  - default DATA_W
  - Mode 0 CPOL/CPHA constants shared with the master.
- Sub-module spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall detect. Three instances: `sclk`, `ss_n`, `mosi` (edges unused on `mosi`).

Test Plan:
- Reset then idle 20 cycles → all outputs at reset values, `miso_oe`=0.
- `tx_load` 0xA5; master sends 0x3C with half period 4 `clk` → `rx_data`=0x3C, single `rx_valid` pulse; MISO sampled by the master = 0xA5; `tx_ready`=1 after LOAD.
- Two back-to-back bytes under one `ss_n` low (0x81, 0x7E); buffer 0x11 preloaded, 0x22 loaded after the first consume → rx gets both words with two `rx_valid` pulses; master reads 0x11 then 0x22.
- Empty buffer at `ss_n` fall, master sends 0xFF → master reads 0x00, `underrun`=1; `tx_load` after `ss_n` high clears it.
- `ss_n` raised after 5 bits of 0xC3 → no `rx_valid`, `rx_data` keeps its previous value, `miso_oe`=0 within SYNC_STAGES+2 cycles.
- Assert `rst_n` low mid-word, release, then a full transfer of 0x5A → clean receive of 0x5A.
